// File: rtl/seg_font_pkg.sv
// Shared 7-segment definitions: active-high hex font table, segment bit order
// and the all-off pattern used by the display drivers.
package seg_font_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Entry n is the active-high {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] FONT_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex nibble to active-high 7-segment pattern (dp not included).
module seg_hex_font
    import seg_font_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = FONT_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit multiplexed hex 7-segment scanner with double-buffered load,
// frame-boundary update, decimal points, leading-zero blanking, per-digit
// blink, global enable and selectable pin polarity.
// rstn asserts asynchronously; its release is expected to be aligned to
// CLK500Hz upstream so the first scan edge after release shows digit 0.
module seg_scan_mux
    import seg_font_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int BLINK_DIV      = 250
)(
    input  logic                      CLK500Hz,
    input  logic                      rstn,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    input  logic                      enable,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [7:0]                seg_out,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    // XOR masks that turn an active-high pattern into pin levels; an all-zero
    // pattern through the mask is therefore the "dark" pin level.
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [7:0]            SEG_INV = {8{SEG_ACTIVE_LOW}} ^ SEG_OFF;

    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic [CNT_W-1:0]        r_blink_cnt;
    logic                    r_blink_ph;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;
    logic                    r_frame_done;

    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_lz_sel;
    logic                    w_blink_sel;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [6:0]              w_font;
    logic [7:0]              w_pattern;
    logic [NUM_DIGITS-1:0]   w_an_onehot;

    // The frame boundary only exists while scanning; a held scan never swaps buffers.
    assign w_wrap = enable && (r_idx == IDX_LAST);

    // Scan index: advance while enabled, wrap after the last digit.
    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
        end else if (enable) begin
            r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Double buffer: loads land in the shadow, the displayed copy only changes at wrap.
    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_disp      <= '0;
            r_disp_dp   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (load) begin
                r_shadow    <= value_in;
                r_shadow_dp <= dp_in;
            end
            if (w_wrap) begin
                if (load) begin
                    r_disp    <= value_in;
                    r_disp_dp <= dp_in;
                end else if (r_pending) begin
                    r_disp    <= r_shadow;
                    r_disp_dp <= r_shadow_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Blink divider runs regardless of enable so blink rate stays steady.
    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
        end
    end

    // Leading-zero mask from the MSB down, then pick out the current digit's data.
    always_comb begin
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_upper_zero = v_upper_zero & (r_disp[4*k +: 4] == 4'h0);
            w_lz_mask[k] = blank_lz & v_upper_zero & (k != 0);
        end
        w_nib       = 4'h0;
        w_dp        = 1'b0;
        w_lz_sel    = 1'b0;
        w_blink_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_disp[4*k +: 4];
                w_dp        = r_disp_dp[k];
                w_lz_sel    = w_lz_mask[k];
                w_blink_sel = blink_en[k];
            end
        end
    end

    seg_hex_font u_font (
        .i_nibble (w_nib),
        .o_seg    (w_font)
    );

    assign w_blank     = w_lz_sel | (r_blink_ph & w_blink_sel);
    assign w_pattern   = {w_dp, w_font};
    assign w_an_onehot = NUM_DIGITS'(1) << r_idx;

    // Output register: drive the digit at r_idx one edge after it is selected.
    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            r_an         <= AN_INV;
            r_seg        <= SEG_INV;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_an         <= AN_INV;
            r_seg        <= SEG_INV;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= (r_idx == IDX_LAST);
            if (w_blank) begin
                r_an  <= AN_INV;
                r_seg <= SEG_INV;
            end else begin
                r_an  <= w_an_onehot ^ AN_INV;
                r_seg <= w_pattern ^ SEG_INV;
            end
        end
    end

    assign an_out     = r_an;
    assign seg_out    = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4-digit active-low instance with a short
// blink divider, plus 8-digit and 1-digit active-high instances.
module tb_seg_scan_mux;

    logic CLK500Hz = 1'b0;
    logic rstn;
    always #5 CLK500Hz = ~CLK500Hz;

    logic [15:0] v4;  logic [3:0] dp4, blk4, an4;  logic ld4, lz4, en4;  logic [7:0] seg4;  logic fd4;
    logic [31:0] v8;  logic [7:0] dp8, blk8, an8;  logic ld8, lz8, en8;  logic [7:0] seg8;  logic fd8;
    logic [3:0]  v1;  logic [0:0] dp1, blk1, an1;  logic ld1, lz1, en1;  logic [7:0] seg1;  logic fd1;

    seg_scan_mux #(.NUM_DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLINK_DIV(4)) u4 (
        .CLK500Hz(CLK500Hz), .rstn(rstn), .value_in(v4), .dp_in(dp4), .load(ld4),
        .blank_lz(lz4), .blink_en(blk4), .enable(en4),
        .an_out(an4), .seg_out(seg4), .frame_done(fd4));

    seg_scan_mux #(.NUM_DIGITS(8), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .BLINK_DIV(250)) u8 (
        .CLK500Hz(CLK500Hz), .rstn(rstn), .value_in(v8), .dp_in(dp8), .load(ld8),
        .blank_lz(lz8), .blink_en(blk8), .enable(en8),
        .an_out(an8), .seg_out(seg8), .frame_done(fd8));

    seg_scan_mux #(.NUM_DIGITS(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .BLINK_DIV(2)) u1 (
        .CLK500Hz(CLK500Hz), .rstn(rstn), .value_in(v1), .dp_in(dp1), .load(ld1),
        .blank_lz(lz1), .blink_en(blk1), .enable(en1),
        .an_out(an1), .seg_out(seg1), .frame_done(fd1));

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK500Hz);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn = 1'b1;
        v4 = '0; dp4 = '0; blk4 = '0; ld4 = 1'b0; lz4 = 1'b0; en4 = 1'b1;
        v8 = '0; dp8 = '0; blk8 = '0; ld8 = 1'b0; lz8 = 1'b0; en8 = 1'b1;
        v1 = '0; dp1 = '0; blk1 = '0; ld1 = 1'b0; lz1 = 1'b0; en1 = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk_eq("rst_an4",  an4,  32'hF);
        chk_eq("rst_seg4", seg4, 32'hFF);
        chk_eq("rst_fd4",  fd4,  32'h0);
        chk_eq("rst_an8",  an8,  32'h00);
        chk_eq("rst_seg1", seg1, 32'h00);
        tick(2);
        rstn = 1'b1;

        // blink on digit 2 from reset; 8- and 1-digit loads
        blk4 = 4'b0100;
        ld8 = 1'b1; v8 = 32'h89AB_CDEF;
        ld1 = 1'b1; v1 = 4'h5; dp1 = 1'b1;
        tick();                                   // e1
        chk_eq("e1_an4",  an4,  32'hE);
        chk_eq("e1_seg4", seg4, 32'hC0);
        chk_eq("e1_seg1", seg1, 32'h3F);
        ld8 = 1'b0; ld1 = 1'b0;
        tick();                                   // e2
        chk_eq("e2_seg1", seg1, 32'hED);
        chk_eq("e2_fd1",  fd1,  32'h1);
        blk1 = 1'b1;
        tick();                                   // e3
        chk_eq("blink_lit_an4", an4, 32'hB);
        chk_eq("blink_dark_an1", an1, 32'h0);
        chk_eq("blink_dark_seg1", seg1, 32'h00);
        tick();                                   // e4
        chk_eq("e4_fd4", fd4, 32'h1);
        tick();                                   // e5
        chk_eq("blink_relit_seg1", seg1, 32'hED);
        blk1 = 1'b0;
        tick();                                   // e6
        chk_eq("steady_an4_d1", an4, 32'hD);
        tick();                                   // e7
        chk_eq("blink_dark_an4",  an4,  32'hF);
        chk_eq("blink_dark_seg4", seg4, 32'hFF);
        tick(2);                                  // e9
        chk_eq("n8_an_d0",  an8,  32'h01);
        chk_eq("n8_seg_d0", seg8, 32'h71);
        tick(2);                                  // e11
        chk_eq("blink_lit2_an4", an4, 32'hB);
        tick();                                   // e12
        chk_eq("n8_an_d3",  an8,  32'h08);
        chk_eq("n8_seg_d3", seg8, 32'h39);
        tick(3);                                  // e15
        chk_eq("blink_dark2_an4", an4, 32'hF);
        chk_eq("n8_fd_early", fd8, 32'h0);
        tick();                                   // e16
        chk_eq("n8_an_d7",  an8,  32'h80);
        chk_eq("n8_seg_d7", seg8, 32'h7F);
        chk_eq("n8_fd",     fd8,  32'h1);
        blk4 = 4'b0000;

        // load 1A2F at idx 0: shown from the next frame
        ld4 = 1'b1; v4 = 16'h1A2F; dp4 = 4'b0000;
        tick();                                   // e17
        ld4 = 1'b0;
        tick();                                   // e18
        chk_eq("preload_seg4", seg4, 32'hC0);
        tick(3);                                  // e21
        chk_eq("ld_an_d0",  an4,  32'hE);
        chk_eq("ld_seg_d0", seg4, 32'h8E);
        chk_eq("ld_fd_d0",  fd4,  32'h0);
        tick();                                   // e22
        chk_eq("ld_an_d1",  an4,  32'hD);
        chk_eq("ld_seg_d1", seg4, 32'hA4);
        tick();                                   // e23
        chk_eq("ld_an_d2",  an4,  32'hB);
        chk_eq("ld_seg_d2", seg4, 32'h88);
        tick();                                   // e24
        chk_eq("ld_an_d3",  an4,  32'h7);
        chk_eq("ld_seg_d3", seg4, 32'hF9);
        chk_eq("ld_fd_d3",  fd4,  32'h1);

        // two mid-frame loads: old value finishes the frame, last load wins
        tick();                                   // e25
        ld4 = 1'b1; v4 = 16'h4321;
        tick();                                   // e26
        chk_eq("mid_old_d1", seg4, 32'hA4);
        v4 = 16'h7654;
        tick();                                   // e27
        ld4 = 1'b0;
        tick();                                   // e28
        chk_eq("mid_old_d3", seg4, 32'hF9);
        tick();                                   // e29
        chk_eq("mid_new_an0", an4,  32'hE);
        chk_eq("mid_new_d0",  seg4, 32'h99);
        tick();                                   // e30
        chk_eq("mid_new_d1",  seg4, 32'h92);
        tick(2);                                  // e32
        chk_eq("mid_new_d3",  seg4, 32'hF8);

        // load on the wrap edge takes effect immediately
        tick(3);                                  // e35
        ld4 = 1'b1; v4 = 16'h8888;
        tick();                                   // e36
        ld4 = 1'b0;
        tick();                                   // e37
        chk_eq("wrapld_an0",  an4,  32'hE);
        chk_eq("wrapld_seg0", seg4, 32'h80);

        // leading-zero blanking with decimal points
        tick(2);                                  // e39
        ld4 = 1'b1; v4 = 16'h00C0; dp4 = 4'b1010; lz4 = 1'b1;
        tick();                                   // e40
        ld4 = 1'b0;
        tick();                                   // e41
        chk_eq("lz_an_d0",  an4,  32'hE);
        chk_eq("lz_seg_d0", seg4, 32'hC0);
        tick();                                   // e42
        chk_eq("lz_an_d1",  an4,  32'hD);
        chk_eq("lz_seg_d1", seg4, 32'h46);
        tick();                                   // e43
        chk_eq("lz_an_d2",  an4,  32'hF);
        chk_eq("lz_seg_d2", seg4, 32'hFF);
        tick();                                   // e44
        chk_eq("lz_an_d3",  an4,  32'hF);
        chk_eq("lz_seg_d3", seg4, 32'hFF);
        lz4 = 1'b0;
        tick(2);                                  // e46
        chk_eq("nolz_seg_d1", seg4, 32'h46);
        tick();                                   // e47
        chk_eq("nolz_an_d2",  an4,  32'hB);
        chk_eq("nolz_seg_d2", seg4, 32'hC0);
        tick();                                   // e48
        chk_eq("nolz_an_d3",  an4,  32'h7);
        chk_eq("nolz_seg_d3", seg4, 32'h40);

        // enable low for 10 edges with idx held at 2
        tick(2);                                  // e50
        en4 = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fd4) fd_cnt++;
            if (i == 0) begin
                chk_eq("dis_an4_first",  an4,  32'hF);
                chk_eq("dis_seg4_first", seg4, 32'hFF);
            end
        end
        chk_eq("dis_an4_last",  an4,    32'hF);
        chk_eq("dis_seg4_last", seg4,   32'hFF);
        chk_eq("dis_fd_count",  fd_cnt, 32'd0);
        en4 = 1'b1;
        tick();                                   // e61
        chk_eq("resume_an_d2",  an4,  32'hB);
        chk_eq("resume_seg_d2", seg4, 32'hC0);
        tick();                                   // e62
        chk_eq("resume_an_d3", an4, 32'h7);
        chk_eq("resume_fd",    fd4, 32'h1);

        // reset mid-frame with a pending load
        tick();                                   // e63
        ld4 = 1'b1; v4 = 16'h9999;
        tick();                                   // e64
        ld4 = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk_eq("midrst_an4",  an4,  32'hF);
        chk_eq("midrst_seg4", seg4, 32'hFF);
        chk_eq("midrst_an8",  an8,  32'h00);
        tick();
        rstn = 1'b1;
        tick();                                   // r1
        chk_eq("post_rst_an0",  an4,  32'hE);
        chk_eq("post_rst_seg0", seg4, 32'hC0);
        tick(3);                                  // r4
        chk_eq("post_rst_fd", fd4, 32'h1);
        tick();                                   // r5
        chk_eq("post_rst_nopend_an",  an4,  32'hE);
        chk_eq("post_rst_nopend_seg", seg4, 32'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
